// File: rtl/func_sweep_ctrl.sv
// func_sweep_ctrl: drives rows 0..15 of the shared {w,x,y,z} bus into the
// truth-table function blocks, waits SETTLE_CYCLES per row, samples f_in
// and streams each row out over a valid/ready handshake while building a
// 16-bit rotate-XOR signature of the whole sweep.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   start, abort    begin sweep (IDLE only) / cancel sweep in progress
//   wxyz            row driven to the function blocks (w=bit3 .. z=bit0)
//   f_in            function outputs, bit k = fk
//   row_valid/ready handshake for row_idx / row_data
//   busy, done      not-IDLE flag, one-cycle pulse after row 15 accepted
//   signature       sweep signature, held until the next start
//
// Optional feature macro: SWEEP_CHECK_EN adds exp_in (golden row value from
// an external ROM) and mism_cnt (count of accepted rows that differ).
module func_sweep_ctrl #(
    parameter int SETTLE_CYCLES = 2,
    parameter int NUM_F         = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    output logic [3:0]       wxyz,
    input  logic [NUM_F-1:0] f_in,
    output logic             row_valid,
    input  logic             row_ready,
    output logic [3:0]       row_idx,
    output logic [NUM_F-1:0] row_data,
    output logic             busy,
    output logic             done,
    output logic [15:0]      signature
`ifdef SWEEP_CHECK_EN
    ,
    input  logic [NUM_F-1:0] exp_in,
    output logic [4:0]       mism_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_WAIT   = 2'd2
    } state_t;

    // Counter is loaded with SETTLE_CYCLES-1 so the capture happens on the
    // last settle cycle, giving exactly SETTLE_CYCLES cycles in SETTLE.
    localparam logic [3:0] LP_CNT_LAST = 4'(SETTLE_CYCLES - 1);

    state_t           r_state;
    logic [3:0]       r_row;
    logic [3:0]       r_cnt;
    logic [3:0]       r_wxyz;
    logic             r_valid;
    logic [3:0]       r_row_idx;
    logic [NUM_F-1:0] r_row_data;
    logic             r_busy;
    logic             r_done;
    logic [15:0]      r_sig;

    logic             w_hs;
    logic [15:0]      w_sig_next;

    assign w_hs       = r_valid & row_ready;
    assign w_sig_next = {r_sig[14:0], r_sig[15]} ^ 16'(r_row_data);

`ifdef SWEEP_CHECK_EN
    logic [4:0] r_mism;
    logic       w_mism_hit;

    assign w_mism_hit = (r_row_data != exp_in);
    assign mism_cnt   = r_mism;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mism <= 5'd0;
        end else if (r_state == ST_IDLE) begin
            if (start && !abort) begin
                r_mism <= 5'd0;
            end
        end else if (r_state == ST_WAIT && !abort && w_hs && w_mism_hit) begin
            r_mism <= r_mism + 5'd1;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_row      <= 4'd0;
            r_cnt      <= 4'd0;
            r_wxyz     <= 4'd0;
            r_valid    <= 1'b0;
            r_row_idx  <= 4'd0;
            r_row_data <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_sig      <= 16'd0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    r_wxyz <= 4'd0;
                    if (start && !abort) begin
                        r_row   <= 4'd0;
                        r_sig   <= 16'd0;
                        r_cnt   <= LP_CNT_LAST;
                        r_busy  <= 1'b1;
                        r_state <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (abort) begin
                        r_state <= ST_IDLE;
                        r_valid <= 1'b0;
                        r_busy  <= 1'b0;
                        r_wxyz  <= 4'd0;
                    end else if (r_cnt == 4'd0) begin
                        r_row_data <= f_in;
                        r_row_idx  <= r_row;
                        r_valid    <= 1'b1;
                        r_state    <= ST_WAIT;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                ST_WAIT: begin
                    // abort wins over a same-cycle handshake; the row is
                    // then not folded into the signature.
                    if (abort) begin
                        r_state <= ST_IDLE;
                        r_valid <= 1'b0;
                        r_busy  <= 1'b0;
                        r_wxyz  <= 4'd0;
                    end else if (w_hs) begin
                        r_sig   <= w_sig_next;
                        r_valid <= 1'b0;
                        if (r_row == 4'd15) begin
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_wxyz  <= 4'd0;
                            r_state <= ST_IDLE;
                        end else begin
                            r_row   <= r_row + 4'd1;
                            r_wxyz  <= r_row + 4'd1;
                            r_cnt   <= LP_CNT_LAST;
                            r_state <= ST_SETTLE;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_valid <= 1'b0;
                    r_busy  <= 1'b0;
                    r_wxyz  <= 4'd0;
                end
            endcase
        end
    end

    assign wxyz      = r_wxyz;
    assign row_valid = r_valid;
    assign row_idx   = r_row_idx;
    assign row_data  = r_row_data;
    assign busy      = r_busy;
    assign done      = r_done;
    assign signature = r_sig;

endmodule

// File: tb/tb_func_sweep_ctrl.sv
// tb_func_sweep_ctrl: directed/randomized sweeps of func_sweep_ctrl
// checked against a row-level reference model.
module tb_func_sweep_ctrl;

    localparam int S     = 2;
    localparam int NUM_F = 10;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic             row_ready = 1'b0;
    logic [3:0]       wxyz;
    logic [NUM_F-1:0] f_in;
    logic             row_valid;
    logic [3:0]       row_idx;
    logic [NUM_F-1:0] row_data;
    logic             busy;
    logic             done;
    logic [15:0]      signature;

    logic [NUM_F-1:0] tbl [16];
    bit               flip [16];
    int               n_vec = 0;
    int               n_err = 0;
    int               m_mism;

    always #5 clk = ~clk;

    // Function blocks modelled as a lookup table indexed by the driven row.
    assign f_in = tbl[wxyz];

`ifdef SWEEP_CHECK_EN
    logic [NUM_F-1:0] exp_in;
    logic [4:0]       mism_cnt;
    assign exp_in = tbl[row_idx] ^ NUM_F'(flip[row_idx]);
`endif

    func_sweep_ctrl #(.SETTLE_CYCLES(S), .NUM_F(NUM_F)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .wxyz      (wxyz),
        .f_in      (f_in),
        .row_valid (row_valid),
        .row_ready (row_ready),
        .row_idx   (row_idx),
        .row_data  (row_data),
        .busy      (busy),
        .done      (done),
        .signature (signature)
`ifdef SWEEP_CHECK_EN
        ,
        .exp_in    (exp_in),
        .mism_cnt  (mism_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] sig_step(input logic [15:0] s,
                                             input logic [NUM_F-1:0] d);
        return {s[14:0], s[15]} ^ 16'(d);
    endfunction

    task automatic fill_tbl(input bit rnd);
        for (int i = 0; i < 16; i++)
            tbl[i] = rnd ? NUM_F'($urandom) : NUM_F'(1);
    endtask

    // One sweep from a start pulse. Cycle 0 is the cycle start is high.
    // Row r becomes valid S+1 cycles after the previous acceptance.
    task automatic sweep(input int rdy_pct, input int stall_row,
                         input int abort_row, input int start_cyc,
                         output logic [15:0] sig_o, output int done_cyc);
        int r = 0;
        int t_next = S + 1;
        int c = 0;
        int stall_n = 0;
        bit fin = 0;
        bit ab = 0;
        bit hs;
        bit vexp;
        logic [15:0] sig = 16'd0;
        m_mism = 0;
        start = 1'b1;
        abort = 1'b0;
        row_ready = 1'b0;
        @(negedge clk);
        c = 1;
        start = 1'b0;
`ifdef SWEEP_CHECK_EN
        chk("mism_clear", mism_cnt, 0);
`endif
        while (!fin && c < 3000) begin
            vexp = (c >= t_next);
            chk("valid", row_valid, vexp);
            chk("busy", busy, 1);
            chk("done_early", done, 0);
            chk("wxyz", wxyz, r[3:0]);
            if (vexp) begin
                chk("row_idx", row_idx, r[3:0]);
                chk("row_data", row_data, tbl[r]);
            end
            row_ready = ($urandom_range(99) < rdy_pct);
            if (vexp && r == stall_row && stall_n < 5) begin
                row_ready = 1'b0;
                stall_n++;
            end
            start = (c == start_cyc);
            hs = vexp && row_ready;
            if (vexp && r == abort_row) begin
                abort = 1'b1;
                row_ready = 1'b1;
            end
            @(negedge clk);
            c++;
            start = 1'b0;
            if (abort) begin
                abort = 1'b0;
                ab = 1;
                fin = 1;
            end else if (hs) begin
                sig = sig_step(sig, tbl[r]);
                if (flip[r]) m_mism++;
                if (r == 15) fin = 1;
                else begin
                    r++;
                    t_next = c + S;
                end
            end
        end
        chk("timeout", fin, 1);
        row_ready = 1'b0;
        chk("end_done", done, !ab);
        chk("end_busy", busy, 0);
        chk("end_valid", row_valid, 0);
        chk("end_wxyz", wxyz, 0);
        chk("signature", signature, sig);
`ifdef SWEEP_CHECK_EN
        if (!ab) chk("mism_cnt", mism_cnt, m_mism);
`endif
        sig_o = sig;
        done_cyc = c;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("idle_done", done, 0);
            chk("idle_busy", busy, 0);
        end
    endtask

    initial begin : stim
        logic [15:0] sg;
        int dc;
        for (int i = 0; i < 16; i++) flip[i] = (i == 2 || i == 9);
        fill_tbl(0);

        // Reset then idle without start.
        #13;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            chk("rst_idle",
                {busy, done, row_valid, wxyz, row_idx, 6'd0, signature},
                32'd0);
            chk("rst_data", row_data, 0);
        end

        // Constant 1 on every row, ready always high.
        sweep(100, 99, 99, -1, sg, dc);
        chk("const_done_cyc", dc, 16 * (S + 1) + 1);
        chk("const_sig", sg, 16'hFFFF);

        // Random table, ready always high, mid-sweep start ignored.
        fill_tbl(1);
        sweep(100, 99, 99, 20, sg, dc);
        chk("rnd_done_cyc", dc, 16 * (S + 1) + 1);

        // Five-cycle stall at row 3.
        fill_tbl(1);
        sweep(100, 3, 99, -1, sg, dc);
        chk("stall_done_cyc", dc, 16 * (S + 1) + 1 + 5);

        // Random backpressure.
        for (int n = 0; n < 4; n++) begin
            fill_tbl(1);
            sweep(60, 99, 99, -1, sg, dc);
        end

        // Abort at row 7 together with ready.
        fill_tbl(1);
        sweep(100, 99, 7, -1, sg, dc);

        // start with abort in IDLE does nothing.
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        chk("start_abort_idle", busy, 0);
        @(negedge clk);
        chk("start_abort_idle2", busy, 0);

        // Asynchronous reset mid-sweep.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        row_ready = 1'b1;
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst", {busy, row_valid, wxyz, row_idx}, 0);
        chk("async_rst_sig", signature, 0);
        @(negedge clk);
        rst_n = 1'b1;
        row_ready = 1'b0;
        @(negedge clk);
        chk("post_rst_busy", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/func_sweep_ctrl.md
Name: func_sweep_ctrl

Overview:
Sequencer that exhaustively exercises the ten 4-input truth-table function blocks (f0..f9) in hardware, replacing the testbench-only input sweep. It drives the shared {w,x,y,z} input bus through rows 0..15 and waits a programmable settle time per row. It then samples the NUM_F-bit function output bus and streams each row out over a valid/ready interface. A 16-bit rotate-XOR signature of the full sweep is accumulated for quick pass/fail comparison.

Parameters:
SETTLE_CYCLES, 2, cycles wxyz is held before sampling f_in; legal 1..15
NUM_F, 10, width of function output bus; legal 1..16

Ports:
clk  input  1  single clock; all state on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  begin sweep; sampled only in IDLE
abort  input  1  cancel sweep in progress
wxyz  output  4  drive to function blocks; w=bit3, x=bit2, y=bit1, z=bit0
f_in  input  NUM_F  function outputs; bit k = fk
row_valid  output  1  row_idx/row_data valid
row_ready  input  1  consumer accepts row
row_idx  output  4  row number of current sample
row_data  output  NUM_F  sampled f_in for row_idx
busy  output  1  high in any state except IDLE
done  output  1  one-cycle pulse after row 15 accepted
signature  output  16  sweep signature; held until next start

Behaviour:
- Reset: state=IDLE; wxyz=0, row_valid=0, row_idx=0, row_data=0, busy=0, done=0, signature=0.
- States: IDLE, SETTLE, WAIT.
- IDLE: wxyz=0. If start=1 and abort=0: row=0, signature cleared, settle counter loaded, next state SETTLE.
- SETTLE: wxyz=row (registered). Stays exactly SETTLE_CYCLES cycles. On the last cycle, f_in is captured into row_data and row_idx=row; next state WAIT with row_valid=1.
- WAIT: row_valid=1. wxyz, row_idx and row_data are held stable until handshake (row_valid & row_ready).
  - On handshake: signature <= {signature[14:0],signature[15]} ^ zero-extended row_data; row_valid drops.
  - If row=15: done=1 for the next cycle and return to IDLE.
  - Otherwise row+1 and go to SETTLE.
- Latency: start at cycle 0, row_ready held 1. Row r is valid at cycle r*(S+1)+S+1. done is high at cycle 16*(S+1)+1, where S=SETTLE_CYCLES.
- Backpressure: unbounded ready-low stalls are legal; outputs must not change while stalled.
- abort (any non-IDLE state): next cycle IDLE, row_valid=0, busy=0, wxyz=0, no done. abort has priority over a handshake in the same cycle; that row is not added to the signature. signature holds its partial value.
- start while busy is ignored. start and abort together in IDLE: stay in IDLE.
- rst_n asserted mid-sweep: immediate return to reset values regardless of clock.
- Row counter does not wrap: the sweep terminates after row 15.

Optional Feature:
SWEEP_CHECK_EN
- Defined: adds input exp_in[NUM_F-1:0] (golden value for the current row_idx, supplied combinationally by an external ROM) and output mism_cnt[4:0]. On each accepted handshake where row_data != exp_in, mism_cnt increments. mism_cnt clears on start and resets to 0; it needs no saturation (max 16).
- Undefined: exp_in and mism_cnt do not exist; no compare logic.

Test Plan:
1. Reset with rst_n=0 then release, no start -> all outputs 0, busy=0, wxyz=0 for 20 cycles.
2. f_in tied 10'h001, row_ready=1, SETTLE_CYCLES=2, start at cycle 0 -> rows 0..15 each with row_data=10'h001; done pulse at cycle 49; signature=16'hFFFF.
3. Real f0..f9 attached, ready=1 -> row 0 row_data=10'h194, row 15 row_data=10'h266, wxyz matches row_idx while row_valid=1.
4. Hold row_ready=0 for 5 cycles at row 3 -> row_valid, row_idx=3, row_data and wxyz=4'h3 all stable; sweep resumes on ready; total done time +5 cycles.
5. abort asserted while row_valid=1 at row 7 with row_ready=1 -> next cycle busy=0, wxyz=0, no done; signature equals value after row 6. A start pulsed mid-sweep in a separate run causes no restart.
6. SWEEP_CHECK_EN defined, exp_in = f_in except bit0 flipped at rows 2 and 9 -> mism_cnt=2 at done; a new start clears it to 0.
